period_meas_sequencer: RTL and testbench

//  Command-driven sequencer for input-period measurement. A start command launches a
//  run that takes a selected edge type and sample count N = 2**avg_log2 and synchronises

---
 rtl/period_meas_sequencer_if.sv | 28 ++
 rtl/period_meas_sequencer.sv | 168 ++++++++++++++++
 tb/tb_period_meas_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/period_meas_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : period_meas_sequencer_if
// Description : Command/status bundle between the register layer and the
//               period measurement sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface period_meas_sequencer_if;
    logic        start;
    logic        abort;
    logic [1:0]  edge_type;
    logic [2:0]  avg_log2;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [19:0] period_avg;

    modport master (
        output start, abort, edge_type, avg_log2,
        input  busy, done, timeout, period_avg
    );

    modport slave (
        input  start, abort, edge_type, avg_log2,
        output busy, done, timeout, period_avg
    );
endinterface
`default_nettype wire

// File: rtl/period_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : period_meas_sequencer
// Description : Measures the period of an asynchronous input, averaging
//               2**avg_log2 full periods after discarding the first edge.
// Revision    : 1.0 - initial release
// ============================================================================
module period_meas_sequencer #(
    parameter int COUNTER_MAX = 100000,
    parameter int MAX_LOG2    = 4
) (
    input  wire logic              clk,
    input  wire logic              as_reset_n,
    input  wire logic              signal_in,
    period_meas_sequencer_if.slave bus
);

    localparam int         c_ACC_W    = 20 + MAX_LOG2;
    localparam int         c_CNT_W    = MAX_LOG2 + 1;
    localparam logic [2:0] c_MAX_LOG2 = 3'(MAX_LOG2);
    localparam logic [19:0] c_CNT_MAX = 20'(COUNTER_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_ff1;
    logic                 r_ff2;
    logic                 r_ff3;
    logic [1:0]           r_edge_type;
    logic [2:0]           r_log2;
    logic [19:0]          r_counter;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout;
    logic [19:0]          r_period_avg;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_both;
    logic                 w_sel_edge;
    logic [2:0]           w_log2_clamped;
    logic [c_CNT_W-1:0]   w_n_target;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_at_max;

    // Synchroniser runs in every state so edges are clean the moment ARM begins
    always_ff @(posedge clk or negedge as_reset_n) begin
        if (!as_reset_n) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
            r_ff3 <= 1'b0;
        end else begin
            r_ff1 <= signal_in;
            r_ff2 <= r_ff1;
            r_ff3 <= r_ff2;
        end
    end

    assign w_rise = r_ff2 & ~r_ff3;
    assign w_fall = ~r_ff2 & r_ff3;
    assign w_both = r_ff2 ^ r_ff3;

    always_comb begin
        w_sel_edge = 1'b0;
        case (r_edge_type)
            2'b00:   w_sel_edge = w_rise;
            2'b01:   w_sel_edge = w_fall;
            2'b10:   w_sel_edge = w_both;
            default: w_sel_edge = 1'b0;
        endcase
    end

    assign w_log2_clamped = (bus.avg_log2 > c_MAX_LOG2) ? c_MAX_LOG2 : bus.avg_log2;
    assign w_n_target     = c_CNT_W'(1) << r_log2;
    assign w_cnt_next     = r_cnt + c_CNT_W'(1);
    assign w_at_max       = (r_counter == c_CNT_MAX);

    always_ff @(posedge clk or negedge as_reset_n) begin
        if (!as_reset_n) begin
            r_state      <= S_IDLE;
            r_edge_type  <= 2'b00;
            r_log2       <= 3'd0;
            r_counter    <= 20'd0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_period_avg <= 20'd0;
        end else begin
            r_done <= 1'b0;
            // Abort outranks everything, including a start in the same cycle
            if (bus.abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_edge_type <= bus.edge_type;
                            r_log2      <= w_log2_clamped;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_counter   <= 20'd1;
                            r_busy      <= 1'b1;
                            if (bus.edge_type == 2'b11) begin
                                r_timeout <= 1'b1;
                                r_state   <= S_DONE;
                            end else begin
                                r_timeout <= 1'b0;
                                r_state   <= S_ARM;
                            end
                        end
                    end
                    S_ARM: begin
                        if (w_sel_edge) begin
                            r_counter <= 20'd1;
                            r_state   <= S_MEASURE;
                        end else if (w_at_max) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_counter <= r_counter + 20'd1;
                        end
                    end
                    S_MEASURE: begin
                        if (w_sel_edge) begin
                            r_acc     <= r_acc + c_ACC_W'(r_counter);
                            r_cnt     <= w_cnt_next;
                            r_counter <= 20'd1;
                            if (w_cnt_next == w_n_target) begin
                                r_state <= S_DONE;
                            end
                        end else if (w_at_max) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_counter <= r_counter + 20'd1;
                        end
                    end
                    S_DONE: begin
                        if (!r_timeout) begin
                            r_period_avg <= 20'(r_acc >> r_log2);
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.period_avg = r_period_avg;

endmodule
`default_nettype wire

// File: tb/tb_period_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_period_meas_sequencer
// Description : Scoreboard bench for period_meas_sequencer with an edge-list
//               reference model; directed cases followed by random runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meas_sequencer;

    logic   clk = 1'b0;
    logic   as_reset_n;
    logic   signal_in;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     model_avg = 0;
    int     gaps[$];

    typedef struct {
        bit     to;
        int     avg;
        longint cyc;
    } exp_t;
    exp_t sb[$];

    period_meas_sequencer_if bus ();

    period_meas_sequencer #(
        .COUNTER_MAX (1000),
        .MAX_LOG2    (4)
    ) dut (
        .clk        (clk),
        .as_reset_n (as_reset_n),
        .signal_in  (signal_in),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: transitions are placed at absolute cycles; the period is simply
    // the distance between successive selected transitions.
    function automatic exp_t predict(input logic [1:0] et, input logic [2:0] lg, input longint k);
        exp_t   e;
        longint t = k + 1;
        longint sel[$];
        int     l = (lg > 3'd4) ? 4 : int'(lg);
        int     n = 1 << l;
        longint sum = 0;
        e.to  = 1'b0;
        e.avg = model_avg;
        e.cyc = -1;
        if (et == 2'd3) begin
            e.to  = 1'b1;
            e.cyc = k + 2;
            return e;
        end
        for (int i = 0; i < gaps.size(); i++) begin
            t += gaps[i];
            if (et == 2'd2 || (et == 2'd0 && i % 2 == 0) || (et == 2'd1 && i % 2 == 1))
                sel.push_back(t);
        end
        if (sel.size() < n + 1) begin
            e.to  = 1'b1;
            e.cyc = (sel.size() == 0) ? k + 1002 : -1;
            return e;
        end
        for (int i = 0; i < n; i++) begin
            if (sel[i+1] - sel[i] > 1000) begin
                e.to = 1'b1;
                return e;
            end
            sum += sel[i+1] - sel[i];
        end
        e.avg     = int'(sum >> l);
        e.cyc     = sel[n] + 4;
        model_avg = e.avg;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (as_reset_n && bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("timeout", bus.timeout, e.to);
                    chk("period_avg", bus.period_avg, e.avg);
                    chk("busy_at_done", bus.busy, 0);
                    if (e.cyc >= 0) chk("done_latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drain(input int bound);
        int c = 0;
        while ((sb.size() != 0 || bus.busy) && c < bound) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            c++;
        end
        chk("drain_queue", sb.size(), 0);
        chk("idle_after_run", bus.busy, 0);
        repeat (6) @(posedge clk);
    endtask

    task automatic do_run(input logic [1:0] et, input logic [2:0] lg,
                          input bit busy_start, input bit scramble);
        longint k;
        exp_t   e;
        @(posedge clk); #1;
        k             = cyc;
        bus.edge_type = et;
        bus.avg_log2  = lg;
        bus.start     = 1'b1;
        e = predict(et, lg, k);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        if (scramble) begin
            bus.edge_type = 2'($urandom);
            bus.avg_log2  = 3'($urandom);
        end
        if (et != 2'd3) begin
            for (int i = 0; i < gaps.size(); i++) begin
                repeat (gaps[i]) begin
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
                signal_in = ~signal_in;
                if (busy_start && i == 1) begin
                    chk("busy_mid_run", bus.busy, 1);
                    bus.edge_type = 2'd3;
                    bus.start     = 1'b1;
                end
            end
        end
        signal_in = 1'b0;
        drain(3000);
    endtask

    task automatic wave(input int first, input int a, input int b, input int toggles);
        gaps.delete();
        gaps.push_back(first);
        for (int i = 1; i < toggles; i++) gaps.push_back((i % 2 == 1) ? a : b);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lg_r;
        int n_r;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.edge_type = 2'd0;
        bus.avg_log2  = 3'd0;
        signal_in     = 1'b0;
        as_reset_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_timeout", bus.timeout, 0);
        chk("reset_avg", bus.period_avg, 0);
        @(negedge clk) as_reset_n = 1'b1;
        repeat (4) @(posedge clk);

        wave(3, 5, 5, 12);               do_run(2'd0, 3'd2, 1'b0, 1'b1);  // square 10
        gaps.delete();                   do_run(2'd0, 3'd2, 1'b0, 1'b0);  // stalled input
        wave(3, 6, 14, 8);               do_run(2'd2, 3'd1, 1'b0, 1'b0);  // 6/14 both edges
        gaps = '{3, 3, 4, 3, 4, 4, 4, 4, 4, 4};
        do_run(2'd1, 3'd2, 1'b0, 1'b0);                                   // 7,8,8,8
        gaps.delete();                   do_run(2'd3, 3'd1, 1'b0, 1'b0);  // illegal edge type
        wave(3, 4, 9, 12);               do_run(2'd0, 3'd1, 1'b1, 1'b0);  // start while busy
        gaps = '{3, 500, 500, 5};        do_run(2'd0, 3'd0, 1'b0, 1'b0);  // sample == max
        gaps = '{3, 500, 501, 5};        do_run(2'd0, 3'd0, 1'b0, 1'b0);  // one past max

        // Abort during MEASURE
        @(posedge clk); #1;
        bus.edge_type = 2'd0; bus.avg_log2 = 3'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat (5) @(posedge clk);
            #1 signal_in = ~signal_in;
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_timeout", bus.timeout, 0);
        chk("abort_avg", bus.period_avg, model_avg);
        signal_in = 1'b0;
        repeat (40) @(posedge clk);

        // Start and abort together in IDLE
        #1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_busy", bus.busy, 0);
        repeat (4) @(posedge clk);

        // Asynchronous reset mid-run
        #1;
        bus.edge_type = 2'd0; bus.avg_log2 = 3'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 signal_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 signal_in = 1'b0;
        repeat (5) @(posedge clk);
        #2 as_reset_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_avg", bus.period_avg, 0);
        chk("rst_timeout", bus.timeout, 0);
        model_avg = 0;
        @(negedge clk) as_reset_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int r = 0; r < 12; r++) begin
            lg_r = int'($urandom_range(0, 7));
            n_r  = 1 << ((lg_r > 4) ? 4 : lg_r);
            gaps.delete();
            gaps.push_back(int'($urandom_range(2, 5)));
            for (int i = 1; i < 2 * (n_r + 2); i++) gaps.push_back(int'($urandom_range(1, 40)));
            do_run(2'($urandom_range(0, 3)), 3'(lg_r), 1'b0, 1'b1);
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
